// File: rtl/elevator_pkg.sv
// Shared encodings and tick defaults for the elevator sequencer, counting and segment blocks.
package elevator_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_FLOOR1     = 3'd1,
    ST_FLOOR2     = 3'd2,
    ST_GOING_TO_1 = 3'd3,
    ST_GOING_TO_2 = 3'd4
  } state_e;

  localparam int BTN_CALL1 = 0;
  localparam int BTN_CALL2 = 1;
  localparam int BTN_HOLD  = 2;

  localparam int DEF_TMR_W         = 16;
  localparam int DEF_DWELL_TICKS   = 50000;
  localparam int DEF_TRAVEL_TICKS  = 50000;
  localparam int DEF_TICKS_PER_SEC = 10000;

endpackage

// File: rtl/elevator_if.sv
// Button pulses in, elevator state bus and status out.
interface elevator_if;
  logic [2:0] btn_stable_shot;
  logic [2:0] state;
  logic       cur_floor;
  logic       door_open;
  logic [1:0] req_pending;
  logic [2:0] sec_left;

  modport master (output btn_stable_shot,
                  input  state, cur_floor, door_open, req_pending, sec_left);
  modport slave  (input  btn_stable_shot,
                  output state, cur_floor, door_open, req_pending, sec_left);
endinterface

// File: rtl/elevator_timer.sv
// Loadable down-counter; load beats run, run stops at zero.
module elevator_timer #(
  parameter int TMR_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [TMR_W-1:0] load_val_i,
  input  logic             run_i,
  output logic [TMR_W-1:0] value_o,
  output logic             zero_o
);

  logic [TMR_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    cnt_q <= '0;
    else if (load_i)               cnt_q <= load_val_i;
    else if (run_i && cnt_q != '0) cnt_q <= cnt_q - 1'b1;
  end

  assign value_o = cnt_q;
  assign zero_o  = (cnt_q == '0);

endmodule

// File: rtl/elevator_ctrl.sv
// Two-floor elevator sequencer: latches calls, owns dwell/travel timing, drives the state bus.
module elevator_ctrl
  import elevator_pkg::*;
#(
  parameter int TMR_W         = DEF_TMR_W,
  parameter int DWELL_TICKS   = DEF_DWELL_TICKS,
  parameter int TRAVEL_TICKS  = DEF_TRAVEL_TICKS,
  parameter int TICKS_PER_SEC = DEF_TICKS_PER_SEC
) (
  input  logic     clk,
  input  logic     rst,
  elevator_if.slave bus
);

  if (DWELL_TICKS < 0 || DWELL_TICKS > (1 << TMR_W) - 1) begin : g_chk_dwell
    $error("DWELL_TICKS does not fit in TMR_W");
  end
  if (TRAVEL_TICKS < 0 || TRAVEL_TICKS > (1 << TMR_W) - 1) begin : g_chk_travel
    $error("TRAVEL_TICKS does not fit in TMR_W");
  end
  if (TICKS_PER_SEC < 1) begin : g_chk_tps
    $error("TICKS_PER_SEC must be positive");
  end

  localparam logic [TMR_W-1:0] DWELL_V  = TMR_W'(DWELL_TICKS);
  localparam logic [TMR_W-1:0] TRAVEL_V = TMR_W'(TRAVEL_TICKS);

  state_e           state_q, state_d;
  logic             cur_floor_q, cur_floor_d;
  logic             door_q;
  logic [1:0]       req_q, req_d;
  logic             tmr_load;
  logic [TMR_W-1:0] tmr_val, tmr_value;
  logic             tmr_zero;

  logic [1:0] calls;
  logic       hold;
  logic       fl;  // floor being served (FLOORx) or targeted (GOING_TO_x)

  assign calls = bus.btn_stable_shot[BTN_CALL2:BTN_CALL1];
  assign hold  = bus.btn_stable_shot[BTN_HOLD];
  assign fl    = (state_q == ST_FLOOR2) || (state_q == ST_GOING_TO_2);

  elevator_timer #(.TMR_W(TMR_W)) u_tmr (
    .clk       (clk),
    .rst_n     (rst),
    .load_i    (tmr_load),
    .load_val_i(tmr_val),
    .run_i     (1'b1),
    .value_o   (tmr_value),
    .zero_o    (tmr_zero)
  );

  always_comb begin
    state_d     = state_q;
    cur_floor_d = cur_floor_q;
    req_d       = req_q | calls;
    tmr_load    = 1'b0;
    tmr_val     = '0;
    case (state_q)
      ST_IDLE: begin
        // Own-floor call beats other-floor call; the other one stays latched.
        if (calls[cur_floor_q] || hold) begin
          state_d               = cur_floor_q ? ST_FLOOR2 : ST_FLOOR1;
          req_d[cur_floor_q]    = 1'b0;
          tmr_load              = 1'b1;
          tmr_val               = DWELL_V;
        end else if (req_d[~cur_floor_q]) begin
          state_d  = cur_floor_q ? ST_GOING_TO_1 : ST_GOING_TO_2;
          tmr_load = 1'b1;
          tmr_val  = TRAVEL_V;
        end
      end
      ST_FLOOR1, ST_FLOOR2: begin
        req_d[fl] = 1'b0;
        if (hold || calls[fl]) begin
          tmr_load = 1'b1;
          tmr_val  = DWELL_V;
        end else if (tmr_zero) begin
          if (req_d[~fl]) begin
            state_d  = fl ? ST_GOING_TO_1 : ST_GOING_TO_2;
            tmr_load = 1'b1;
            tmr_val  = TRAVEL_V;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_GOING_TO_1, ST_GOING_TO_2: begin
        if (tmr_zero) begin
          state_d     = fl ? ST_FLOOR2 : ST_FLOOR1;
          cur_floor_d = fl;
          req_d[fl]   = 1'b0;
          tmr_load    = 1'b1;
          tmr_val     = DWELL_V;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        req_d    = req_q;
        tmr_load = 1'b1;
        tmr_val  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cur_floor_q <= 1'b0;
      req_q       <= 2'b00;
      door_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_floor_q <= cur_floor_d;
      req_q       <= req_d;
      door_q      <= (state_d == ST_FLOOR1) || (state_d == ST_FLOOR2);
    end
  end

  logic [31:0] secs;
  assign secs = (32'(tmr_value) + 32'(TICKS_PER_SEC - 1)) / 32'(TICKS_PER_SEC);

  assign bus.state       = state_q;
  assign bus.cur_floor   = cur_floor_q;
  assign bus.door_open   = door_q;
  assign bus.req_pending = req_q;
  assign bus.sec_left    = (secs > 32'd7) ? 3'd7 : secs[2:0];

endmodule

// File: tb/tb_elevator_ctrl.sv
// Scoreboard bench: stimulus queues time-stamped expectations, a negedge monitor compares them.
module tb_elevator_ctrl;

  logic clk = 1'b0;
  logic rst, rst2;
  int   ecnt = 0;
  int   n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) ecnt <= ecnt + 1;

  elevator_if bus0 ();
  elevator_if bus1 ();

  elevator_ctrl #(.TMR_W(16), .DWELL_TICKS(20), .TRAVEL_TICKS(30), .TICKS_PER_SEC(5)) u_dut (
    .clk(clk), .rst(rst), .bus(bus0.slave));

  elevator_ctrl u_dflt (.clk(clk), .rst(rst2), .bus(bus1.slave));

  typedef struct {
    int         when;
    string      name;
    logic [9:0] exp;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  function automatic logic [9:0] pk(logic [2:0] st, logic cf, logic dr, logic [1:0] rq, logic [2:0] sl);
    return {st, cf, dr, rq, sl};
  endfunction

  task automatic e0(int w, string nm, logic [2:0] st, logic cf, logic dr, logic [1:0] rq, logic [2:0] sl);
    q0.push_back('{w, nm, pk(st, cf, dr, rq, sl)});
  endtask

  task automatic e1(int w, string nm, logic [2:0] st, logic cf, logic dr, logic [1:0] rq, logic [2:0] sl);
    q1.push_back('{w, nm, pk(st, cf, dr, rq, sl)});
  endtask

  task automatic cmp(exp_t e, logic [9:0] act);
    n_cmp++;
    if (e.when != ecnt) begin
      n_bad++;
      $display("FAIL %s: expectation for cycle %0d reached at cycle %0d", e.name, e.when, ecnt);
    end else if (act !== e.exp) begin
      n_bad++;
      $display("FAIL %s @%0d: got st=%0d cf=%b door=%b req=%b sec=%0d, want st=%0d cf=%b door=%b req=%b sec=%0d",
               e.name, ecnt, act[9:7], act[6], act[5], act[4:3], act[2:0],
               e.exp[9:7], e.exp[6], e.exp[5], e.exp[4:3], e.exp[2:0]);
    end
  endtask

  always @(negedge clk) begin
    while (q0.size() > 0 && q0[0].when <= ecnt)
      cmp(q0.pop_front(), {bus0.state, bus0.cur_floor, bus0.door_open, bus0.req_pending, bus0.sec_left});
    while (q1.size() > 0 && q1[0].when <= ecnt)
      cmp(q1.pop_front(), {bus1.state, bus1.cur_floor, bus1.door_open, bus1.req_pending, bus1.sec_left});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(int t);
    while (ecnt < t) tick();
  endtask

  task automatic main_seq();
    int t, f, h, g;
    t = ecnt;
    e0(t, "reset", 3'd0, 1'b0, 1'b0, 2'b00, 3'd0);
    tick();
    // 1: call floor 2 from idle at floor 1
    bus0.btn_stable_shot = 3'b010; tick(); bus0.btn_stable_shot = 3'b000;
    t = ecnt;
    e0(t,      "t1_depart",   3'd4, 1'b0, 1'b0, 2'b10, 3'd6);
    e0(t + 30, "t1_tmr0",     3'd4, 1'b0, 1'b0, 2'b10, 3'd0);
    e0(t + 31, "t1_arrive",   3'd2, 1'b1, 1'b1, 2'b00, 3'd4);
    e0(t + 51, "t1_dwell0",   3'd2, 1'b1, 1'b1, 2'b00, 3'd0);
    e0(t + 52, "t1_idle",     3'd0, 1'b1, 1'b0, 2'b00, 3'd0);
    wait_until(t + 52);
    // 2: hold extends dwell, including on the timer==0 cycle
    bus0.btn_stable_shot = 3'b100; tick(); bus0.btn_stable_shot = 3'b000;
    f = ecnt;
    e0(f,      "t2_open",     3'd2, 1'b1, 1'b1, 2'b00, 3'd4);
    e0(f + 17, "t2_tmr3",     3'd2, 1'b1, 1'b1, 2'b00, 3'd1);
    wait_until(f + 17);
    bus0.btn_stable_shot = 3'b100; tick(); bus0.btn_stable_shot = 3'b000;
    e0(f + 18, "t2_reload",   3'd2, 1'b1, 1'b1, 2'b00, 3'd4);
    e0(f + 38, "t2_tmr0",     3'd2, 1'b1, 1'b1, 2'b00, 3'd0);
    wait_until(f + 38);
    bus0.btn_stable_shot = 3'b100; tick(); bus0.btn_stable_shot = 3'b000;
    e0(f + 39, "t2_reload0",  3'd2, 1'b1, 1'b1, 2'b00, 3'd4);
    e0(f + 59, "t2_last",     3'd2, 1'b1, 1'b1, 2'b00, 3'd0);
    e0(f + 60, "t2_idle",     3'd0, 1'b1, 1'b0, 2'b00, 3'd0);
    wait_until(f + 60);
    // back to floor 1
    bus0.btn_stable_shot = 3'b001; tick(); bus0.btn_stable_shot = 3'b000;
    h = ecnt;
    e0(h,      "ret_depart",  3'd3, 1'b1, 1'b0, 2'b01, 3'd6);
    e0(h + 31, "ret_arrive",  3'd1, 1'b0, 1'b1, 2'b00, 3'd4);
    e0(h + 52, "ret_idle",    3'd0, 1'b0, 1'b0, 2'b00, 3'd0);
    wait_until(h + 52);
    // 3: both calls together; 4: call floor 1 during travel
    bus0.btn_stable_shot = 3'b011; tick(); bus0.btn_stable_shot = 3'b000;
    g = ecnt;
    e0(g,      "t3_both",     3'd1, 1'b0, 1'b1, 2'b10, 3'd4);
    e0(g + 20, "t3_tmr0",     3'd1, 1'b0, 1'b1, 2'b10, 3'd0);
    e0(g + 21, "t3_depart",   3'd4, 1'b0, 1'b0, 2'b10, 3'd6);
    wait_until(g + 29);
    bus0.btn_stable_shot = 3'b001; tick(); bus0.btn_stable_shot = 3'b000;
    e0(g + 30, "t4_latch",    3'd4, 1'b0, 1'b0, 2'b11, 3'd5);
    e0(g + 51, "t4_tmr0",     3'd4, 1'b0, 1'b0, 2'b11, 3'd0);
    e0(g + 52, "t4_arrive",   3'd2, 1'b1, 1'b1, 2'b01, 3'd4);
    e0(g + 72, "t4_dwell0",   3'd2, 1'b1, 1'b1, 2'b01, 3'd0);
    e0(g + 73, "t4_direct",   3'd3, 1'b1, 1'b0, 2'b01, 3'd6);
    e0(g + 90, "t5_tmr13",    3'd3, 1'b1, 1'b0, 2'b01, 3'd3);
    wait_until(g + 91);
    // 5: async reset mid-travel, timer=12
    rst = 1'b0;
    e0(g + 91, "t5_async",    3'd0, 1'b0, 1'b0, 2'b00, 3'd0);
    wait_until(g + 93);
    rst = 1'b1;
    e0(g + 94, "t5_release",  3'd0, 1'b0, 1'b0, 2'b00, 3'd0);
    e0(g + 96, "t5_idle",     3'd0, 1'b0, 1'b0, 2'b00, 3'd0);
    wait_until(g + 97);
  endtask

  task automatic dflt_seq();
    int d;
    // 6: sec_left rounding at default parameters during a 50000-tick dwell
    bus1.btn_stable_shot = 3'b001; tick(); bus1.btn_stable_shot = 3'b000;
    d = ecnt;
    e1(d,         "t6_50000", 3'd1, 1'b0, 1'b1, 2'b00, 3'd5);
    e1(d + 9999,  "t6_40001", 3'd1, 1'b0, 1'b1, 2'b00, 3'd5);
    e1(d + 10000, "t6_40000", 3'd1, 1'b0, 1'b1, 2'b00, 3'd4);
    e1(d + 40000, "t6_10000", 3'd1, 1'b0, 1'b1, 2'b00, 3'd1);
    e1(d + 49999, "t6_1",     3'd1, 1'b0, 1'b1, 2'b00, 3'd1);
    e1(d + 50000, "t6_0",     3'd1, 1'b0, 1'b1, 2'b00, 3'd0);
    e1(d + 50001, "t6_idle",  3'd0, 1'b0, 1'b0, 2'b00, 3'd0);
    wait_until(d + 50001);
  endtask

  initial begin
    rst = 1'b0;
    rst2 = 1'b0;
    bus0.btn_stable_shot = 3'b000;
    bus1.btn_stable_shot = 3'b000;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    rst2 = 1'b1;
    fork
      main_seq();
      dflt_seq();
    join
    tick();
    tick();
    foreach (q0[i]) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: never compared (due cycle %0d)", q0[i].name, q0[i].when);
    end
    foreach (q1[i]) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: never compared (due cycle %0d)", q1[i].name, q1[i].when);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/elevator_ctrl.md
Name: elevator_ctrl

Overview:
Master sequencer for the two-floor elevator. Consumes one-cycle debounced button pulses, latches floor calls, and drives the shared 3-bit elevator state bus. That bus feeds the segment and counting logic. Owns the dwell and travel timers, so door-open time and travel time are decided here, not downstream. Sits between the button debouncer and the display and counting blocks.

Parameters:
TMR_W, 16, width of the internal tick timer
DWELL_TICKS, 50000, clk ticks loaded on door open (5 s at 10 kHz)
TRAVEL_TICKS, 50000, clk ticks loaded on departure (5 s at 10 kHz)
TICKS_PER_SEC, 10000, divisor for the sec_left display value

Ports:
clk  in  1  system clock, 10 kHz
rst  in  1  asynchronous, active-low reset
btn_stable_shot  in  3  one-cycle button pulses: [0] call floor 1, [1] call floor 2, [2] door hold/open
state  out  3  elevator state bus: 0 IDLE, 1 FLOOR1, 2 FLOOR2, 3 GOING_TO_1, 4 GOING_TO_2
cur_floor  out  1  last floor reached: 0 = floor 1, 1 = floor 2
door_open  out  1  high exactly while state is FLOOR1 or FLOOR2
req_pending  out  2  latched calls: [0] floor 1, [1] floor 2
sec_left  out  3  ceil(timer / TICKS_PER_SEC), saturated at 7; 0 in IDLE

Behaviour:
- Reset: asynchronous assert on rst low, synchronous release.
  - Reset values: state=IDLE, cur_floor=0, req_pending=0, door_open=0, timer=0.
  - Reset mid-travel or mid-dwell abandons the operation. Home is floor 1.
- Outputs: all registered except sec_left, which is combinational from the timer. A pulse sampled at edge n is reflected in the outputs after edge n.
- Call latching:
  - btn[k] sets req_pending[k] in any state, unless it is served in the same cycle (rules below).
  - req_pending[k] clears on entry to FLOOR(k+1).
- IDLE (door closed, timer=0):
  - Call for cur_floor, or btn[2] -> FLOOR(cur_floor); timer=DWELL_TICKS; that call is not latched.
  - Call for the other floor -> GOING_TO_other; timer=TRAVEL_TICKS.
  - A pending other-floor call with no button activity -> GOING_TO_other.
  - Both calls in the same cycle: serve cur_floor first (FLOOR), latch the other.
- FLOOR1 / FLOOR2 (door open):
  - Timer decrements by 1 per clk.
  - btn[2], or a call for this floor, reloads DWELL_TICKS (extend) and is not latched.
  - On an edge where timer==0 with no reload:
    - if the other-floor request is pending -> GOING_TO_other, timer=TRAVEL_TICKS;
    - else -> IDLE.
  - Unextended dwell = DWELL_TICKS+1 cycles. A reload on the timer==0 cycle wins and the door stays open.
- GOING_TO_1 / GOING_TO_2 (door closed):
  - Timer decrements by 1 per clk. btn[2] is ignored. Calls are latched.
  - On timer==0 -> FLOOR(target): cur_floor=target, clear req_pending[target], timer=DWELL_TICKS.
  - A call for the target floor during travel is absorbed by arrival.
  - A call for the departed floor stays latched and is served after the dwell.
  - Travel time = TRAVEL_TICKS+1 cycles.
- Timer arithmetic:
  - Timer never underflows; it holds 0 in IDLE.
  - DWELL_TICKS and TRAVEL_TICKS must fit in TMR_W; this is checked by an elaboration assertion.
- sec_left: 0 when timer=0; otherwise the smallest s with s*TICKS_PER_SEC >= timer, capped at 7. At defaults, 50000 -> 5, 40001 -> 5, 40000 -> 4, 1 -> 1.
- Illegal state codes 5-7 -> IDLE on the next edge, timer=0. Requests are kept.

Decomposition:
- Package elevator_pkg holds:
  - state encodings ST_IDLE..ST_GOING_TO_2 (3-bit);
  - button indices BTN_CALL1=0, BTN_CALL2=1, BTN_HOLD=2;
  - default tick constants.
  The package is shared with the counting and segment blocks.
- One sub-module, elevator_timer: loadable TMR_W down-counter.
  - Inputs: load, load_val, run.
  - Outputs: value, zero.
  - Load has priority over run. Run holds at 0.
- The FSM and request latches live in elevator_ctrl.

Test Plan:
Use DWELL_TICKS=20, TRAVEL_TICKS=30, TICKS_PER_SEC=5 unless noted.
1. Reset, then btn[1] pulse at cycle 10 -> state=4 at cycle 11; state=2 after 31 cycles, cur_floor=1, req_pending=0, door_open=1; IDLE after 21 more cycles.
2. In FLOOR2, pulse btn[2] when timer=3 -> timer reloads 20; door stays open 21 further cycles; pulse on the timer==0 cycle also extends.
3. In IDLE at floor 1, btn[0] and btn[1] in the same cycle -> FLOOR1, req_pending=2'b10; after 21 cycles GOING_TO_2, then FLOOR2 with req_pending=0.
4. During GOING_TO_2 pulse btn[0] -> req_pending[0]=1; after arrival and dwell -> GOING_TO_1 directly, no IDLE cycle.
5. Drop rst low asynchronously mid-travel (timer=12) -> outputs go to reset values before the next edge; rst high -> IDLE, cur_floor=0.
6. Defaults: sample sec_left at timer 50000, 40001, 40000, 10000, 1, 0 -> 5, 5, 4, 1, 1, 0.
